// File: rtl/pokey_pot_scan_ctrl_if.sv
// Bus between POKEY register decode / read mux and the pot scan controller.
// The master drives the scan strobes and raw comparator lines; the slave returns the latched results.
interface pokey_pot_scan_ctrl_if #(
    parameter int unsigned NUM_POTS = 8
);
    logic                      ce_slow;
    logic                      ce_fast;
    logic                      fast_scan;
    logic                      potgo;
    logic [NUM_POTS-1:0]       pot_in;
    logic [8*NUM_POTS-1:0]     pot_val;
    logic [NUM_POTS-1:0]       allpot;
    logic                      pot_dump;
    logic                      scanning;

    modport master (
        output ce_slow, ce_fast, fast_scan, potgo, pot_in,
        input  pot_val, allpot, pot_dump, scanning
    );

    modport slave (
        input  ce_slow, ce_fast, fast_scan, potgo, pot_in,
        output pot_val, allpot, pot_dump, scanning
    );
endinterface

// File: rtl/pokey_pot_scan_ctrl.sv
// POKEY paddle measurement sequencer: dump capacitors, count scan ticks,
// latch each line's count when its synchronized comparator input rises.
module pokey_pot_scan_ctrl #(
    parameter int unsigned NUM_POTS   = 8,
    parameter int unsigned POT_MAX    = 228,
    parameter int unsigned DUMP_TICKS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pokey_pot_scan_ctrl_if.slave  bus
);
    localparam int unsigned DW = $clog2(DUMP_TICKS + 1);

    typedef enum logic [1:0] {IDLE, DUMP, SCAN} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             count_q, count_d;
    logic [DW-1:0]          dump_q, dump_d;
    logic [8*NUM_POTS-1:0]  pot_val_q, pot_val_d;
    logic [NUM_POTS-1:0]    allpot_q, allpot_d;
    logic [NUM_POTS-1:0]    sync1_q, sync2_q, sync3_q;
    logic                   pot_dump_q, pot_dump_d;
    logic                   scanning_q, scanning_d;
    logic                   tick;
    logic                   at_max;

    assign tick = bus.fast_scan ? bus.ce_fast : bus.ce_slow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            dump_q     <= '0;
            pot_val_q  <= '0;
            allpot_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            pot_dump_q <= 1'b1;
            scanning_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dump_q     <= dump_d;
            pot_val_q  <= pot_val_d;
            allpot_q   <= allpot_d;
            sync1_q    <= bus.pot_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            pot_dump_q <= pot_dump_d;
            scanning_q <= scanning_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        dump_d    = dump_q;
        pot_val_d = pot_val_q;
        allpot_d  = allpot_q;
        at_max    = (count_q == 8'(POT_MAX));

        // POTGO restarts the measurement from any state and swallows a coincident tick.
        if (bus.potgo) begin
            state_d  = DUMP;
            count_d  = '0;
            dump_d   = '0;
            allpot_d = '1;
        end else if (tick) begin
            case (state_q)
                DUMP: begin
                    if (dump_q == DW'(DUMP_TICKS - 1)) begin
                        state_d = SCAN;
                        count_d = '0;
                    end else begin
                        dump_d = dump_q + DW'(1);
                    end
                end
                SCAN: begin
                    // At terminal count every unfinished line latches POT_MAX.
                    for (int unsigned i = 0; i < NUM_POTS; i++) begin
                        if (allpot_q[i] && (sync3_q[i] || at_max)) begin
                            pot_val_d[8*i +: 8] = count_q;
                            allpot_d[i]         = 1'b0;
                        end
                    end
                    if (at_max) begin
                        state_d = IDLE;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end

        pot_dump_d = (state_d != SCAN);
        scanning_d = (state_d != IDLE);
    end

    assign bus.pot_val  = pot_val_q;
    assign bus.allpot   = allpot_q;
    assign bus.pot_dump = pot_dump_q;
    assign bus.scanning = scanning_q;
endmodule

// File: tb/tb_pokey_pot_scan_ctrl.sv
// Directed bench for pokey_pot_scan_ctrl: a cycle table for mode/potgo/sync
// interplay, then hand sequences for reset, long scans and terminal count.
module tb_pokey_pot_scan_ctrl;
    logic clk;
    logic reset;

    pokey_pot_scan_ctrl_if #(.NUM_POTS(8)) bus ();

    pokey_pot_scan_ctrl #(
        .NUM_POTS  (8),
        .POT_MAX   (228),
        .DUMP_TICKS(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic        potgo;
        logic        ce_slow;
        logic        ce_fast;
        logic        fast_scan;
        logic [7:0]  pot_in;
        logic [7:0]  exp_allpot;
        logic        exp_dump;
        logic        exp_scan;
        logic [63:0] exp_val;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_potgo();
        bus.potgo = 1'b1;
        @(negedge clk);
        bus.potgo = 1'b0;
    endtask

    task automatic tick_s(input int n);
        repeat (n) begin
            bus.ce_slow = 1'b1;
            @(negedge clk);
            bus.ce_slow = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic tick_f(input int n);
        repeat (n) begin
            bus.ce_fast = 1'b1;
            @(negedge clk);
            bus.ce_fast = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.ce_slow   = 1'b0;
        bus.ce_fast   = 1'b0;
        bus.fast_scan = 1'b0;
        bus.potgo     = 1'b0;
        bus.pot_in    = '0;
        cyc(2);
        reset = 1'b0;

        chk("rst_allpot",   64'(bus.allpot),   64'h0);
        chk("rst_pot_dump", 64'(bus.pot_dump), 64'h1);
        chk("rst_scanning", 64'(bus.scanning), 64'h0);
        chk("rst_pot_val",  bus.pot_val,       64'h0);

        // potgo, slow, fast, mode, pot_in | allpot, dump, scan, pot_val
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h24, 8'hFF, 1'b1, 1'b1, 64'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h24, 8'hFF, 1'b1, 1'b1, 64'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h24, 8'hFF, 1'b1, 1'b1, 64'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h24, 8'hFF, 1'b0, 1'b1, 64'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h24, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h24, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h24, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h24, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h25, 8'hDB, 1'b0, 1'b1, 64'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 8'hDA, 1'b0, 1'b1, 64'h02};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h25, 8'hFF, 1'b1, 1'b1, 64'h02};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 8'hFF, 1'b0, 1'b1, 64'h02};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 8'hDA, 1'b0, 1'b1, 64'h0};

        for (int i = 0; i < 16; i++) begin
            bus.potgo     = vecs[i].potgo;
            bus.ce_slow   = vecs[i].ce_slow;
            bus.ce_fast   = vecs[i].ce_fast;
            bus.fast_scan = vecs[i].fast_scan;
            bus.pot_in    = vecs[i].pot_in;
            @(negedge clk);
            chk($sformatf("vec%0d_allpot", i), 64'(bus.allpot),   64'(vecs[i].exp_allpot));
            chk($sformatf("vec%0d_dump", i),   64'(bus.pot_dump), 64'(vecs[i].exp_dump));
            chk($sformatf("vec%0d_scan", i),   64'(bus.scanning), 64'(vecs[i].exp_scan));
            chk($sformatf("vec%0d_val", i),    bus.pot_val,       vecs[i].exp_val);
        end
        bus.potgo   = 1'b0;
        bus.ce_slow = 1'b0;
        bus.ce_fast = 1'b0;

        // Reset while in SCAN with latched values.
        tick_f(1);
        do_reset();
        chk("midscan_rst_val",    bus.pot_val,       64'h0);
        chk("midscan_rst_allpot", 64'(bus.allpot),   64'h0);
        chk("midscan_rst_dump",   64'(bus.pot_dump), 64'h1);
        chk("midscan_rst_scan",   64'(bus.scanning), 64'h0);

        // Slow mode: line 0 at count 10, line 1 at count 32, then potgo at count 50.
        bus.fast_scan = 1'b0;
        bus.pot_in    = '0;
        pulse_potgo();
        tick_s(1);
        tick_s(10);
        bus.pot_in = 8'h01;
        cyc(4);
        tick_s(1);
        chk("line0_cnt10",    64'(bus.pot_val[7:0]), 64'h0A);
        chk("line0_allpot",   64'(bus.allpot),       64'hFE);
        tick_s(21);
        bus.pot_in = 8'h03;
        cyc(4);
        tick_s(1);
        chk("line1_cnt32",    64'(bus.pot_val[15:8]), 64'h20);
        tick_s(17);
        pulse_potgo();
        chk("rego_allpot",    64'(bus.allpot),        64'hFF);
        chk("rego_val_keep",  64'(bus.pot_val[15:0]), 64'h200A);
        chk("rego_dump",      64'(bus.pot_dump),      64'h1);
        chk("rego_scan",      64'(bus.scanning),      64'h1);
        tick_s(1);
        chk("rego_scan_entry", 64'(bus.pot_dump),     64'h0);
        tick_s(1);
        chk("rego_count0",    64'(bus.pot_val[15:0]), 64'h0000);
        chk("rego_allpot2",   64'(bus.allpot),        64'hFC);

        // No line ever rises: every line latches the terminal count.
        do_reset();
        bus.pot_in = '0;
        pulse_potgo();
        tick_s(229);
        chk("pre_max_scan",   64'(bus.scanning), 64'h1);
        chk("pre_max_allpot", 64'(bus.allpot),   64'hFF);
        tick_s(1);
        chk("max_val",        bus.pot_val,       {8{8'hE4}});
        chk("max_allpot",     64'(bus.allpot),   64'h0);
        chk("max_scan",       64'(bus.scanning), 64'h0);
        chk("max_dump",       64'(bus.pot_dump), 64'h1);
        tick_s(2);
        chk("idle_hold_val",  bus.pot_val,       {8{8'hE4}});

        // Fast mode, ce_slow ignored.
        do_reset();
        bus.fast_scan = 1'b1;
        pulse_potgo();
        tick_f(1);
        tick_f(100);
        bus.pot_in = 8'h08;
        cyc(4);
        tick_f(1);
        chk("fast_line3",     64'(bus.pot_val[31:24]), 64'h64);
        chk("fast_allpot",    64'(bus.allpot),         64'hF7);
        bus.pot_in = 8'h18;
        cyc(4);
        tick_s(2);
        chk("fast_slow_ign",  64'(bus.allpot),         64'hF7);
        tick_f(1);
        chk("fast_line4",     64'(bus.pot_val[39:32]), 64'h65);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
